// File: rtl/display_arbiter.sv
// display_arbiter
//   Time-shares a four-digit seven-segment display between three requesters.
//   Requests are served round-robin. Each grant holds the display for at least
//   2^HOLDBITS clocks. Optional leading-zero blanking is applied to the digits.
//
// Ports
//   clk              system clock, rising edge
//   reset            synchronous, active-high reset
//   req[2:0]         request levels, bit i = requester i
//   val0/val1/val2   16-bit value offered by each requester
//   lzb              leading-zero blank enable
//   A, B, C, D       digit nibbles, A = value[15:12] ... D = value[3:0]
//   blank[3:0]       per-digit dark flags, bit3 = A ... bit0 = D
//   grant[2:0]       one-hot current owner, 000 when idle
//   busy             high while a grant is being shown
module display_arbiter #(
  parameter int HOLDBITS = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [15:0] val0,
  input  logic [15:0] val1,
  input  logic [15:0] val2,
  input  logic        lzb,
  output logic [3:0]  A,
  output logic [3:0]  B,
  output logic [3:0]  C,
  output logic [3:0]  D,
  output logic [3:0]  blank,
  output logic [2:0]  grant,
  output logic        busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHOW = 1'b1;

  localparam logic [HOLDBITS-1:0] CNT_ONE = {{(HOLDBITS-1){1'b0}}, 1'b1};

  logic [0:0]          state_reg, state_next;
  logic [HOLDBITS-1:0] cnt_reg, cnt_next;
  logic [1:0]          last_reg, last_next;
  logic [15:0]         latched_reg, latched_next;

  // While showing, last_reg always names the current owner, so a single
  // round-robin search rooted at last_reg serves both the idle contest and
  // the expiry contest (where the owner itself is the final candidate).
  logic [1:0]  cand1, cand2, win;
  logic [15:0] win_val, own_val;

  always_comb begin
    cand1 = (last_reg == 2'd2) ? 2'd0 : last_reg + 2'd1;
    cand2 = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;
    if (req[cand1])
      win = cand1;
    else if (req[cand2])
      win = cand2;
    else
      win = last_reg;
  end

  always_comb begin
    case (win)
      2'd1:    win_val = val1;
      2'd2:    win_val = val2;
      default: win_val = val0;
    endcase
    case (last_reg)
      2'd1:    own_val = val1;
      2'd2:    own_val = val2;
      default: own_val = val0;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    last_next    = last_reg;
    latched_next = latched_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next   = SHOW;
          last_next    = win;
          cnt_next     = '0;
          latched_next = win_val;
        end
      end
      SHOW: begin
        cnt_next = cnt_reg + CNT_ONE;
        if (&cnt_reg) begin
          // Hold window expires this cycle: hand over without a gap, or idle.
          if (|req) begin
            last_next    = win;
            cnt_next     = '0;
            latched_next = win_val;
          end else begin
            state_next   = IDLE;
            latched_next = '0;
          end
        end else if (req[last_reg]) begin
          latched_next = own_val;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output values are derived from next-state so every output is a register
  // and reflects inputs sampled on the same edge (including lzb).
  logic        show_next;
  logic [15:0] disp_next;
  logic [3:1]  nib_zero;
  logic [3:1]  lead_zero;
  logic [3:0]  blank_next;
  logic [2:0]  grant_next;

  assign show_next = (state_next == SHOW);
  assign disp_next = show_next ? latched_next : 16'h0000;

  genvar gi;
  generate
    for (gi = 1; gi <= 3; gi++) begin : g_zero
      assign nib_zero[gi] = (disp_next[4*gi +: 4] == 4'h0);
    end
    // A digit is a leading zero when it and everything to its left are zero.
    assign lead_zero[3] = nib_zero[3];
    for (gi = 1; gi <= 2; gi++) begin : g_lead
      assign lead_zero[gi] = nib_zero[gi] & lead_zero[gi+1];
    end
  endgenerate

  always_comb begin
    if (!show_next)
      blank_next = 4'b1111;
    else if (lzb)
      blank_next = {lead_zero, 1'b0};
    else
      blank_next = 4'b0000;
  end

  assign grant_next = show_next ? (3'b001 << last_next) : 3'b000;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      last_reg    <= 2'd2;
      latched_reg <= 16'h0000;
      A           <= 4'h0;
      B           <= 4'h0;
      C           <= 4'h0;
      D           <= 4'h0;
      blank       <= 4'b1111;
      grant       <= 3'b000;
      busy        <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      last_reg    <= last_next;
      latched_reg <= latched_next;
      A           <= disp_next[15:12];
      B           <= disp_next[11:8];
      C           <= disp_next[7:4];
      D           <= disp_next[3:0];
      blank       <= blank_next;
      grant       <= grant_next;
      busy        <= show_next;
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter
//   Directed scenarios followed by a randomized phase. Every cycle the DUT
//   outputs are compared with a behavioural model that tracks owner, age of
//   the current grant and the shown value with plain integers.
module tb_display_arbiter;

  localparam int HB   = 3;
  localparam int HOLD = 1 << HB;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [15:0] val0, val1, val2;
  logic        lzb;
  logic [3:0]  A, B, C, D;
  logic [3:0]  blank;
  logic [2:0]  grant;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // model state
  int          m_owner = -1;
  int          m_last  = 2;
  int          m_age   = 0;
  int          m_val   = 0;
  logic        m_lzb   = 1'b0;

  always #5 clk = ~clk;

  display_arbiter #(.HOLDBITS(HB)) dut (
    .clk(clk), .reset(reset), .req(req),
    .val0(val0), .val1(val1), .val2(val2), .lzb(lzb),
    .A(A), .B(B), .C(C), .D(D),
    .blank(blank), .grant(grant), .busy(busy)
  );

  function automatic int val_of(int i);
    if (i == 0) return int'(val0);
    if (i == 1) return int'(val1);
    return int'(val2);
  endfunction

  // First requester found scanning base+1, base+2, base+3 (mod 3).
  function automatic int pick(int base, logic [2:0] r);
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (base + k) % 3;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int w;
    m_lzb = lzb;
    if (reset) begin
      m_owner = -1; m_last = 2; m_age = 0; m_val = 0;
    end else if (m_owner < 0) begin
      w = pick(m_last, req);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_age = 1; m_val = val_of(w);
      end
    end else if (m_age == HOLD) begin
      w = pick(m_owner, req);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_age = 1; m_val = val_of(w);
      end else begin
        m_owner = -1; m_age = 0; m_val = 0;
      end
    end else begin
      m_age = m_age + 1;
      if (req[m_owner]) m_val = val_of(m_owner);
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    int exp_grant, exp_blank, exp_disp, n;
    if (m_owner < 0) begin
      exp_grant = 0; exp_blank = 15; exp_disp = 0;
    end else begin
      exp_grant = 1 << m_owner;
      exp_disp  = m_val;
      exp_blank = 0;
      if (m_lzb) begin
        n = 0;
        while (n < 3 && ((m_val >> (12 - 4 * n)) % 16) == 0) n++;
        exp_blank = (15 << (4 - n)) & 15;
      end
    end
    chk("grant", {13'd0, grant}, 16'(exp_grant));
    chk("busy",  {15'd0, busy},  16'(m_owner >= 0 ? 1 : 0));
    chk("digits", {A, B, C, D},  16'(exp_disp));
    chk("blank", {12'd0, blank}, 16'(exp_blank));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] lz_vals [4];
    logic [3:0]  lz_exp  [4];
    lz_vals = '{16'h0000, 16'h00A0, 16'h0F00, 16'h1000};
    lz_exp  = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};

    reset = 1'b1; req = 3'b000; lzb = 1'b0;
    val0 = 16'h0; val1 = 16'h0; val2 = 16'h0;

    // 1. reset state with all requests high
    req = 3'b111;
    tick(); tick();
    chk("rst_grant", {13'd0, grant}, 16'h0000);
    chk("rst_blank", {12'd0, blank}, 16'h000F);
    chk("rst_digits", {A, B, C, D}, 16'h0000);
    reset = 1'b0;
    tick();
    chk("rst_first_grant", {13'd0, grant}, 16'h0001);
    $display("step reset: grant=%b blank=%b", grant, blank);

    // 2. single requester holds continuously
    do_reset();
    req = 3'b010; val1 = 16'h12AB;
    for (int i = 0; i < 24; i++) tick();
    chk("single_grant", {13'd0, grant}, 16'h0002);
    chk("single_digits", {A, B, C, D}, 16'h12AB);
    $display("step single: grant=%b digits=%h", grant, {A, B, C, D});

    // 3. round-robin rotation
    do_reset();
    req = 3'b111; val0 = 16'h1111; val1 = 16'h2222; val2 = 16'h3333;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (i == 1)  chk("rr_g0", {13'd0, grant}, 16'h0001);
      if (i == 9)  chk("rr_g1", {13'd0, grant}, 16'h0002);
      if (i == 17) chk("rr_g2", {13'd0, grant}, 16'h0004);
      if (i == 25) chk("rr_g3", {13'd0, grant}, 16'h0001);
    end
    $display("step rotate: grant=%b digits=%h", grant, {A, B, C, D});

    // 4. early drop freezes the display until expiry
    do_reset();
    req = 3'b001; val0 = 16'h1111;
    tick();
    val0 = 16'h2222;
    tick();
    req = 3'b000; val0 = 16'h3333;
    for (int i = 3; i <= 8; i++) tick();
    chk("drop_frozen", {A, B, C, D}, 16'h2222);
    chk("drop_busy", {15'd0, busy}, 16'h0001);
    tick();
    chk("drop_idle_blank", {12'd0, blank}, 16'h000F);
    chk("drop_idle_grant", {13'd0, grant}, 16'h0000);
    $display("step drop: grant=%b blank=%b", grant, blank);

    // 5. leading-zero blanking
    do_reset();
    req = 3'b001; lzb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      val0 = lz_vals[i];
      tick();
      chk("lzb_on", {12'd0, blank}, {12'd0, lz_exp[i]});
    end
    lzb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      val0 = lz_vals[i];
      tick();
      chk("lzb_off", {12'd0, blank}, 16'h0000);
    end
    $display("step lzb: blank=%b", blank);

    // 6. reset in the middle of a grant
    do_reset();
    req = 3'b010; val1 = 16'h4321;
    for (int i = 0; i < 5; i++) tick();
    req = 3'b101;
    reset = 1'b1;
    tick();
    chk("midrst_grant", {13'd0, grant}, 16'h0000);
    chk("midrst_busy", {15'd0, busy}, 16'h0000);
    chk("midrst_blank", {12'd0, blank}, 16'h000F);
    chk("midrst_digits", {A, B, C, D}, 16'h0000);
    reset = 1'b0;
    tick();
    chk("midrst_regrant", {13'd0, grant}, 16'h0001);
    $display("step midreset: grant=%b", grant);

    // randomized phase against the model
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] mask;
      reset = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 5) == 0) req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) lzb = ~lzb;
      case ($urandom_range(0, 3))
        0:       mask = 16'h000F;
        1:       mask = 16'h00FF;
        2:       mask = 16'h0FFF;
        default: mask = 16'hFFFF;
      endcase
      val0 = 16'($urandom) & mask;
      val1 = 16'($urandom) & mask;
      val2 = 16'($urandom) & mask;
      tick();
    end
    $display("step random: grant=%b digits=%h", grant, {A, B, C, D});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
